// File: rtl/alu_issue_seq_if.sv
// rtl/alu_issue_seq_if.sv - instruction, register-file and ALU signal bundle for alu_issue_seq
interface alu_issue_seq_if #(
    parameter int W    = 8,
    parameter int RA_W = 3
);
    logic            InstValid;
    logic [8:0]      Inst;
    logic            InstReady;
    logic [RA_W-1:0] RfRdAddr;
    logic [W-1:0]    RfRdData;
    logic            RfWe;
    logic [RA_W-1:0] RfWrAddr;
    logic [W-1:0]    RfWrData;
    logic [3:0]      AluOp;
    logic [W-1:0]    AluA;
    logic [W-1:0]    AluB;
    logic            AluOvIn;
    logic [W-1:0]    AluOut;
    logic            AluOvOut;

    modport master (
        input  InstValid, Inst, RfRdData, AluOut, AluOvOut,
        output InstReady, RfRdAddr, RfWe, RfWrAddr, RfWrData, AluOp, AluA, AluB, AluOvIn
    );

    modport slave (
        output InstValid, Inst, RfRdData, AluOut, AluOvOut,
        input  InstReady, RfRdAddr, RfWe, RfWrAddr, RfWrData, AluOp, AluA, AluB, AluOvIn
    );
endinterface

// File: rtl/alu_issue_seq.sv
// rtl/alu_issue_seq.sv - serial issue sequencer driving the 8-bit ALU from a single-read-port register file
module alu_issue_seq #(
    parameter int W     = 8,
    parameter int RA_W  = 3,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    alu_issue_seq_if.master  bus,
    output logic             OvFlag,
    output logic             Done,
    output logic [CNT_W-1:0] Retired
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        EXEC = 3'd3,
        WB   = 3'd4,
        HALT = 3'd5
    } seqStateT;

    localparam logic [3:0] OP_STORE = 4'b0011;
    localparam logic [3:0] OP_RST   = 4'b1010;
    localparam logic [3:0] OP_HALT  = 4'b1011;

    seqStateT        state;
    seqStateT        nextState;
    logic            accept;
    logic [3:0]      op;
    logic [RA_W-1:0] ra;
    logic [RA_W-1:0] rb;
    logic [W-1:0]    opA;
    logic [W-1:0]    opB;
    logic            writesRf;

    // store, rst and halt produce no register-file update
    assign writesRf    = !(op == OP_STORE || op == OP_RST || op == OP_HALT);
    assign bus.AluOvIn = OvFlag;

    // state register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // next state, handshake and ALU operand drive; operands are steady across EXEC and WB
    always_comb begin
        nextState     = state;
        accept        = 1'b0;
        bus.InstReady = 1'b0;
        Done          = 1'b0;
        bus.AluOp     = OP_HALT;
        bus.AluA      = '0;
        bus.AluB      = '0;
        case (state)
            IDLE: begin
                bus.InstReady = 1'b1;
                if (bus.InstValid) begin
                    accept    = 1'b1;
                    nextState = RD_A;
                end
            end
            RD_A: nextState = RD_B;
            RD_B: nextState = EXEC;
            EXEC: begin
                // opB is still in flight from the read port, so forward it directly
                bus.AluOp = op;
                bus.AluA  = opA;
                bus.AluB  = bus.RfRdData;
                nextState = WB;
            end
            WB: begin
                bus.AluOp = op;
                bus.AluA  = opA;
                bus.AluB  = opB;
                nextState = (op == OP_HALT) ? HALT : IDLE;
            end
            HALT: Done = 1'b1;
            default: nextState = IDLE;
        endcase
    end

    // instruction latch, operand capture, writeback, flag and retire counter
    always_ff @(posedge Clk) begin
        if (Reset) begin
            op           <= '0;
            ra           <= '0;
            rb           <= '0;
            opA          <= '0;
            opB          <= '0;
            bus.RfRdAddr <= '0;
            bus.RfWe     <= 1'b0;
            bus.RfWrAddr <= '0;
            bus.RfWrData <= '0;
            OvFlag       <= 1'b0;
            Retired      <= '0;
        end else begin
            bus.RfWe <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op           <= bus.Inst[8:5];
                        ra           <= RA_W'(bus.Inst[4:2]);
                        rb           <= RA_W'(bus.Inst[1:0]);
                        bus.RfRdAddr <= RA_W'(bus.Inst[4:2]);
                    end
                end
                RD_A: bus.RfRdAddr <= rb;
                RD_B: opA <= bus.RfRdData;
                EXEC: opB <= bus.RfRdData;
                WB: begin
                    bus.RfWrData <= bus.AluOut;
                    bus.RfWrAddr <= ra;
                    bus.RfWe     <= writesRf;
                    OvFlag       <= bus.AluOvOut;
                    if (op != OP_HALT) begin
                        Retired <= Retired + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_seq.sv
// tb/tb_alu_issue_seq.sv - randomized and directed bench for alu_issue_seq against an instruction-level model
module tb_alu_issue_seq;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_issue_seq_if bus0 ();
    alu_issue_seq_if bus1 ();

    logic        ovFlag0, done0, ovFlag1, done1;
    logic [15:0] retired0;
    logic [1:0]  retired1;

    alu_issue_seq #(.W(8), .RA_W(3), .CNT_W(16)) dut0 (
        .Clk(clk), .Reset(reset), .bus(bus0.master),
        .OvFlag(ovFlag0), .Done(done0), .Retired(retired0)
    );

    // narrow-counter copy runs in lockstep on the same instruction stream
    alu_issue_seq #(.W(8), .RA_W(3), .CNT_W(2)) dut1 (
        .Clk(clk), .Reset(reset), .bus(bus1.master),
        .OvFlag(ovFlag1), .Done(done1), .Retired(retired1)
    );

    // ALU behaviour: {carryOut, result}
    function automatic logic [8:0] aluRef(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic ci);
        case (op)
            4'b0000: return {1'b0, a} + {1'b0, b} + 9'(ci);
            4'b0001: return {ci, a ^ b};
            4'b0010: return {ci, a & b};
            4'b0100: return {ci, b};
            4'b0101: return {ci, a | b};
            4'b1010: return 9'h000;
            default: return {ci, a};
        endcase
    endfunction

    logic [8:0] alu0, alu1;
    assign alu0 = aluRef(bus0.AluOp, bus0.AluA, bus0.AluB, bus0.AluOvIn);
    assign alu1 = aluRef(bus1.AluOp, bus1.AluA, bus1.AluB, bus1.AluOvIn);
    assign bus0.AluOut   = alu0[7:0];
    assign bus0.AluOvOut = alu0[8];
    assign bus1.AluOut   = alu1[7:0];
    assign bus1.AluOvOut = alu1[8];

    // register file with one synchronous read port; preload overrides any same-edge write
    logic [7:0] rfMem [8];
    logic [7:0] preVals [8];
    logic       preAll = 1'b0;
    logic [7:0] rdData;
    always @(posedge clk) begin
        rdData <= rfMem[bus0.RfRdAddr];
        if (bus0.RfWe) rfMem[bus0.RfWrAddr] <= bus0.RfWrData;
        if (preAll) for (int i = 0; i < 8; i++) rfMem[i] <= preVals[i];
    end
    assign bus0.RfRdData  = rdData;
    assign bus1.RfRdData  = rdData;
    assign bus1.InstValid = bus0.InstValid;
    assign bus1.Inst      = bus0.Inst;

    // instruction-level reference model
    logic [7:0]  rfM [8];
    logic        ovM;
    logic [15:0] retM;
    logic        expWe;
    logic [2:0]  expAddr;
    logic [7:0]  expData;

    int vectors = 0;
    int miscompares = 0;

    // observations from the last issued instruction
    int         obsWaited, obsWe, obsWeCycle, obsLow, obsDoneCycle;
    logic [2:0] obsWeAddr;
    logic [7:0] obsWeData, obsAExec, obsBExec, obsAWb, obsBWb;
    logic [3:0] obsOpExec, obsOpWb;
    logic       obsOvIn;

    task automatic modelReset();
        ovM  = 1'b0;
        retM = 16'd0;
    endtask

    task automatic modelIssue(input logic [8:0] inst);
        logic [3:0] op;
        logic [2:0] ra, rb;
        logic [8:0] r;
        op = inst[8:5];
        ra = inst[4:2];
        rb = {1'b0, inst[1:0]};
        r  = aluRef(op, rfM[ra], rfM[rb], ovM);
        expWe   = !(op == 4'b0011 || op == 4'b1010 || op == 4'b1011);
        expAddr = ra;
        expData = r[7:0];
        if (expWe) rfM[ra] = r[7:0];
        ovM = r[8];
        if (op != 4'b1011) retM = retM + 16'd1;
    endtask

    task automatic syncRf();
        for (int i = 0; i < 8; i++) preVals[i] = rfM[i];
        preAll = 1'b1;
        @(posedge clk);
        #1 preAll = 1'b0;
        @(negedge clk);
    endtask

    task automatic doReset();
        reset = 1'b1;
        bus0.InstValid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        modelReset();
    endtask

    // issue one instruction at a negedge and watch nObs cycles after the accept edge
    task automatic execInst(input logic [8:0] inst, input bit holdValid, input int nObs);
        obsWaited = 0;
        while (bus0.InstReady !== 1'b1 && obsWaited < 20) begin
            @(negedge clk);
            obsWaited++;
        end
        bus0.Inst = inst;
        bus0.InstValid = 1'b1;
        @(negedge clk);
        if (holdValid) bus0.Inst = 9'b0000_00101;
        else bus0.InstValid = 1'b0;
        obsWe = 0; obsWeCycle = -1; obsLow = 0; obsDoneCycle = -1;
        for (int c = 1; c <= nObs; c++) begin
            if (bus0.RfWe === 1'b1) begin
                obsWe++; obsWeAddr = bus0.RfWrAddr; obsWeData = bus0.RfWrData; obsWeCycle = c;
            end
            if (bus0.InstReady !== 1'b1) obsLow++;
            if (done0 === 1'b1 && obsDoneCycle < 0) obsDoneCycle = c;
            if (c == 3) begin
                obsOvIn = bus0.AluOvIn; obsAExec = bus0.AluA; obsBExec = bus0.AluB; obsOpExec = bus0.AluOp;
            end
            if (c == 4) begin
                obsAWb = bus0.AluA; obsBWb = bus0.AluB; obsOpWb = bus0.AluOp;
            end
            if (c < nObs) @(negedge clk);
        end
        bus0.InstValid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus0.InstValid = 1'b0;
        bus0.Inst = 9'd0;
        repeat (3) @(negedge clk);
        vectors++; if (bus0.InstReady !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", bus0.InstReady); end
        vectors++; if (ovFlag0 !== 1'b0) begin miscompares++; $display("FAIL reset_ovflag: got %b want 0", ovFlag0); end
        vectors++; if (done0 !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done0); end
        vectors++; if (retired0 !== 16'd0) begin miscompares++; $display("FAIL reset_retired: got %0d want 0", retired0); end
        vectors++; if (bus0.RfWe !== 1'b0) begin miscompares++; $display("FAIL reset_rfwe: got %b want 0", bus0.RfWe); end
        vectors++; if (bus0.RfRdAddr !== 3'd0 || bus0.RfWrAddr !== 3'd0 || bus0.RfWrData !== 8'd0) begin
            miscompares++; $display("FAIL reset_regs: got rd=%0d wa=%0d wd=%h want 0", bus0.RfRdAddr, bus0.RfWrAddr, bus0.RfWrData); end
        vectors++; if (bus0.AluOp !== 4'b1011 || bus0.AluA !== 8'd0 || bus0.AluB !== 8'd0) begin
            miscompares++; $display("FAIL reset_alu: got op=%b a=%h b=%h want 1011/00/00", bus0.AluOp, bus0.AluA, bus0.AluB); end
        vectors++; if (retired1 !== 2'd0) begin miscompares++; $display("FAIL reset_retired_narrow: got %0d want 0", retired1); end
        reset = 1'b0;
        modelReset();
        for (int i = 0; i < 8; i++) rfM[i] = 8'd0;
        syncRf();
    endtask

    task automatic test_add();
        rfM[1] = 8'h7F; rfM[2] = 8'h01;
        syncRf();
        modelIssue(9'b0000_001_10);
        execInst(9'b0000_001_10, 1'b0, 5);
        vectors++; if (obsWaited !== 0) begin miscompares++; $display("FAIL add_accept: waited %0d want 0", obsWaited); end
        vectors++; if (obsWe !== 1) begin miscompares++; $display("FAIL add_we_count: got %0d want 1", obsWe); end
        vectors++; if (obsWeCycle !== 5) begin miscompares++; $display("FAIL add_we_cycle: got %0d want 5", obsWeCycle); end
        vectors++; if (obsWeAddr !== 3'd1 || obsWeData !== 8'h80) begin
            miscompares++; $display("FAIL add_write: got addr=%0d data=%h want 1/80", obsWeAddr, obsWeData); end
        vectors++; if (obsLow !== 4) begin miscompares++; $display("FAIL add_ready_low: got %0d want 4", obsLow); end
        vectors++; if (ovFlag0 !== 1'b0) begin miscompares++; $display("FAIL add_ovflag: got %b want 0", ovFlag0); end
        vectors++; if (retired0 !== 16'd1) begin miscompares++; $display("FAIL add_retired: got %0d want 1", retired0); end
        vectors++; if (obsOpExec !== 4'b0000 || obsAExec !== 8'h7F || obsBExec !== 8'h01) begin
            miscompares++; $display("FAIL add_alu_exec: got op=%b a=%h b=%h want 0000/7f/01", obsOpExec, obsAExec, obsBExec); end
        vectors++; if (obsOpWb !== 4'b0000 || obsAWb !== 8'h7F || obsBWb !== 8'h01) begin
            miscompares++; $display("FAIL add_alu_wb: got op=%b a=%h b=%h want 0000/7f/01", obsOpWb, obsAWb, obsBWb); end
    endtask

    task automatic test_carry_chain();
        rfM[1] = 8'hFF; rfM[2] = 8'h01; rfM[0] = 8'h00; rfM[3] = 8'h00;
        syncRf();
        modelIssue(9'b0000_001_10);
        execInst(9'b0000_001_10, 1'b0, 5);
        vectors++; if (obsWe !== 1 || obsWeData !== 8'h00) begin
            miscompares++; $display("FAIL carry_first: got we=%0d data=%h want 1/00", obsWe, obsWeData); end
        vectors++; if (ovFlag0 !== 1'b1) begin miscompares++; $display("FAIL carry_flag_set: got %b want 1", ovFlag0); end
        modelIssue(9'b0000_000_11);
        execInst(9'b0000_000_11, 1'b0, 5);
        vectors++; if (obsOvIn !== 1'b1) begin miscompares++; $display("FAIL carry_ovin: got %b want 1", obsOvIn); end
        vectors++; if (obsWe !== 1 || obsWeAddr !== 3'd0 || obsWeData !== 8'h01) begin
            miscompares++; $display("FAIL carry_second: got we=%0d addr=%0d data=%h want 1/0/01", obsWe, obsWeAddr, obsWeData); end
        vectors++; if (ovFlag0 !== 1'b0) begin miscompares++; $display("FAIL carry_flag_clear: got %b want 0", ovFlag0); end
        vectors++; if (retired0 !== 16'd3) begin miscompares++; $display("FAIL carry_retired: got %0d want 3", retired0); end
    endtask

    task automatic test_non_writing();
        rfM[4] = 8'hFF; rfM[1] = 8'h01;
        syncRf();
        modelIssue(9'b0000_100_01);
        execInst(9'b0000_100_01, 1'b0, 5);
        vectors++; if (ovFlag0 !== 1'b1) begin miscompares++; $display("FAIL nw_setup_flag: got %b want 1", ovFlag0); end
        modelIssue(9'b0011_010_01);
        execInst(9'b0011_010_01, 1'b0, 5);
        vectors++; if (obsWe !== 0) begin miscompares++; $display("FAIL nw_store_we: got %0d pulses want 0", obsWe); end
        vectors++; if (ovFlag0 !== 1'b1) begin miscompares++; $display("FAIL nw_store_flag: got %b want 1", ovFlag0); end
        modelIssue(9'b1010_011_10);
        execInst(9'b1010_011_10, 1'b0, 5);
        vectors++; if (obsWe !== 0) begin miscompares++; $display("FAIL nw_rst_we: got %0d pulses want 0", obsWe); end
        vectors++; if (ovFlag0 !== 1'b0) begin miscompares++; $display("FAIL nw_rst_flag: got %b want 0", ovFlag0); end
        vectors++; if (retired0 !== 16'd6) begin miscompares++; $display("FAIL nw_retired: got %0d want 6", retired0); end
    endtask

    task automatic test_reset_mid();
        int wes;
        rfM[1] = 8'hFF; rfM[2] = 8'h01;
        syncRf();
        modelIssue(9'b0000_001_10);
        execInst(9'b0000_001_10, 1'b0, 5);
        vectors++; if (ovFlag0 !== 1'b1) begin miscompares++; $display("FAIL mid_setup_flag: got %b want 1", ovFlag0); end
        bus0.Inst = 9'b0000_001_10;
        bus0.InstValid = 1'b1;
        @(negedge clk);
        bus0.InstValid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        vectors++; if (bus0.InstReady !== 1'b1) begin miscompares++; $display("FAIL mid_ready: got %b want 1", bus0.InstReady); end
        vectors++; if (ovFlag0 !== 1'b0) begin miscompares++; $display("FAIL mid_ovflag: got %b want 0", ovFlag0); end
        vectors++; if (retired0 !== 16'd0) begin miscompares++; $display("FAIL mid_retired: got %0d want 0", retired0); end
        wes = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus0.RfWe === 1'b1) wes++;
            @(negedge clk);
        end
        vectors++; if (wes !== 0) begin miscompares++; $display("FAIL mid_no_write: got %0d pulses want 0", wes); end
    endtask

    task automatic test_counter_wrap();
        int         wrapSeq [5] = '{1, 2, 3, 0, 1};
        logic [8:0] inst;
        doReset();
        for (int i = 0; i < 8; i++) rfM[i] = 8'($urandom);
        syncRf();
        for (int k = 0; k < 5; k++) begin
            inst = {4'b0100, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            modelIssue(inst);
            execInst(inst, 1'b0, 5);
            vectors++; if (retired1 !== 2'(wrapSeq[k])) begin
                miscompares++; $display("FAIL wrap_retired[%0d]: got %0d want %0d", k, retired1, wrapSeq[k]); end
            vectors++; if (obsWe !== 1 || obsWeAddr !== expAddr || obsWeData !== expData) begin
                miscompares++; $display("FAIL wrap_mov[%0d]: got we=%0d addr=%0d data=%h want 1/%0d/%h", k, obsWe, obsWeAddr, obsWeData, expAddr, expData); end
        end
    endtask

    task automatic test_random();
        logic [8:0] inst;
        logic [3:0] op;
        for (int i = 0; i < 8; i++) rfM[i] = 8'($urandom);
        syncRf();
        for (int n = 0; n < 40; n++) begin
            do op = 4'($urandom_range(0, 15)); while (op == 4'b1011);
            inst = {op, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            repeat ($urandom_range(0, 2)) @(negedge clk);
            modelIssue(inst);
            execInst(inst, 1'($urandom_range(0, 1)), 5);
            vectors++; if (obsWaited !== 0 || obsLow !== 4) begin
                miscompares++; $display("FAIL rand_handshake[%0d]: waited=%0d low=%0d want 0/4", n, obsWaited, obsLow); end
            vectors++; if (obsWe !== (expWe ? 1 : 0)) begin
                miscompares++; $display("FAIL rand_we[%0d] op=%b: got %0d pulses want %0d", n, op, obsWe, expWe); end
            if (expWe) begin
                vectors++; if (obsWeAddr !== expAddr || obsWeData !== expData || obsWeCycle !== 5) begin
                    miscompares++; $display("FAIL rand_write[%0d]: got addr=%0d data=%h cyc=%0d want %0d/%h/5", n, obsWeAddr, obsWeData, obsWeCycle, expAddr, expData); end
            end
            vectors++; if (ovFlag0 !== ovM) begin miscompares++; $display("FAIL rand_ovflag[%0d]: got %b want %b", n, ovFlag0, ovM); end
            vectors++; if (retired0 !== retM || retired1 !== retM[1:0]) begin
                miscompares++; $display("FAIL rand_retired[%0d]: got %0d/%0d want %0d/%0d", n, retired0, retired1, retM, retM[1:0]); end
        end
    endtask

    task automatic test_halt();
        modelIssue(9'b1011_010_01);
        execInst(9'b1011_010_01, 1'b1, 10);
        vectors++; if (obsWaited !== 0) begin miscompares++; $display("FAIL halt_accept: waited %0d want 0", obsWaited); end
        vectors++; if (obsDoneCycle !== 5) begin miscompares++; $display("FAIL halt_done_cycle: got %0d want 5", obsDoneCycle); end
        vectors++; if (obsLow !== 10) begin miscompares++; $display("FAIL halt_ready_low: got %0d want 10", obsLow); end
        vectors++; if (obsWe !== 0) begin miscompares++; $display("FAIL halt_we: got %0d pulses want 0", obsWe); end
        vectors++; if (retired0 !== retM) begin miscompares++; $display("FAIL halt_retired: got %0d want %0d", retired0, retM); end
        vectors++; if (done0 !== 1'b1 || done1 !== 1'b1) begin miscompares++; $display("FAIL halt_done_hold: got %b/%b want 1/1", done0, done1); end
    endtask

    initial begin
        reset = 1'b1;
        bus0.InstValid = 1'b0;
        bus0.Inst = 9'd0;
        test_reset();
        test_add();
        test_carry_chain();
        test_non_writing();
        test_reset_mid();
        test_counter_wrap();
        test_random();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
